// File: rtl/data_mem_ctrl.sv
// M-stage data memory controller: sizes, aligns and extends loads/stores onto a word bus with ack timeout.
// Define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of silently aligning them.
module data_mem_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] r_data,
    output logic             stall_m,
    output logic             bus_req,
    output logic             bus_we,
    output logic [WIDTH-1:0] bus_addr,
    output logic [3:0]       bus_be,
    output logic [WIDTH-1:0] bus_wdata,
    input  logic [WIDTH-1:0] bus_rdata,
    input  logic             bus_ack,
    output logic             bus_err,
    output logic             misalign_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] count;
    logic [1:0]    offset;
    logic [2:0]    f3;
    logic          access;
    logic          misaligned;
    logic          timeout;

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   lane_be = 4'b0001 << off;
            2'b01:   lane_be = 4'b0011 << {off[1], 1'b0};
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] lane_wdata(input logic [1:0] size, input logic [WIDTH-1:0] d);
        case (size)
            2'b00:   lane_wdata = WIDTH'({4{d[7:0]}});
            2'b01:   lane_wdata = WIDTH'({2{d[15:0]}});
            default: lane_wdata = d;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] load_ext(input logic [2:0] code, input logic [1:0] off,
                                                  input logic [WIDTH-1:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (code)
            3'b000:  load_ext = {{(WIDTH-8){b[7]}}, b};
            3'b001:  load_ext = {{(WIDTH-16){h[15]}}, h};
            3'b100:  load_ext = {{(WIDTH-8){1'b0}}, b};
            3'b101:  load_ext = {{(WIDTH-16){1'b0}}, h};
            default: load_ext = word;
        endcase
    endfunction

    assign access  = mem_read | mem_write;
    assign stall_m = access & (state != RESP);
    assign timeout = (count == CW'(TIMEOUT - 1));

`ifdef MISALIGN_TRAP_EN
    assign misaligned = ((funct3[1:0] == 2'b01) && address[0]) ||
                        (funct3[1] && (address[1:0] != 2'b00));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) misalign_err <= 1'b0;
        else       misalign_err <= (state == IDLE) && access && misaligned;
    end
`else
    assign misaligned   = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access) state_nxt = misaligned ? RESP : WAIT;
            WAIT:    if (bus_ack || timeout) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            offset    <= 2'b00;
            f3        <= 3'b000;
            r_data    <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= 4'b0000;
            bus_wdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (access && misaligned) begin
                        r_data <= '0;
                    end else if (access) begin
                        // mem_write wins when both strobes are high
                        bus_req   <= 1'b1;
                        bus_we    <= mem_write;
                        bus_addr  <= {address[WIDTH-1:2], 2'b00};
                        bus_be    <= lane_be(funct3[1:0], address[1:0]);
                        bus_wdata <= lane_wdata(funct3[1:0], w_data);
                        count     <= '0;
                        offset    <= address[1:0];
                        f3        <= funct3;
                    end
                end
                WAIT: begin
                    if (bus_ack) begin
                        bus_req <= 1'b0;
                        if (!bus_we) r_data <= load_ext(f3, offset, bus_rdata);
                    end else if (timeout) begin
                        bus_req <= 1'b0;
                        r_data  <= '0;
                        bus_err <= 1'b1;
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
